// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the on-chip memory.
// The m1_lock signal exists only when MEM_ARB_LOCK_EN is defined.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic [AW-1:0] m0_addr;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;
`ifdef MEM_ARB_LOCK_EN
  logic          m1_lock;
`endif

  logic          mem_wen;
  logic [AW-1:0] mem_w_addr;
  logic [DW-1:0] mem_w_data;
  logic          mem_ren;
  logic [AW-1:0] mem_r_addr;
  logic [DW-1:0] mem_r_data;

  // Environment side: both requesting masters plus the memory itself.
  modport master (
`ifdef MEM_ARB_LOCK_EN
    output m1_lock,
`endif
    output m0_req, m0_addr,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_wen, mem_w_addr, mem_w_data, mem_ren, mem_r_addr,
    output mem_r_data
  );

  modport slave (
`ifdef MEM_ARB_LOCK_EN
    input  m1_lock,
`endif
    input  m0_req, m0_addr,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_wen, mem_w_addr, mem_w_data, mem_ren, mem_r_addr,
    input  mem_r_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin two-master arbiter for the single-port-per-direction on-chip memory.
// Optional MEM_ARB_LOCK_EN adds m1_lock so that master 1 can hold the memory for atomic RMW.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                clk,
  input  logic                rstn,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    NONE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  owner_e        state_q, state_d;
  logic          last_q;          // index of the most recently granted master
  logic          lock_q;
  logic          gnt0, gnt1;
  logic          wen, ren;
  logic [AW-1:0] w_addr, r_addr;
  logic [DW-1:0] w_data;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;

  // Reset is folded into the grant so that no memory access is issued while rstn is low.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rstn) begin
      if (bus.m1_req && (lock_q || !bus.m0_req || !last_q)) gnt1 = 1'b1;
      else if (bus.m0_req)                                   gnt0 = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rstn)              last_q <= 1'b1;
    else if (gnt0 || gnt1)  last_q <= gnt1;
  end

`ifdef MEM_ARB_LOCK_EN
  // The lock survives only while m1 keeps being granted with m1_lock set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lock_q <= 1'b0;
    else       lock_q <= gnt1 && bus.m1_lock;
  end
`else
  assign lock_q = 1'b0;
`endif

  always_comb begin
    wen    = 1'b0;
    ren    = 1'b0;
    w_addr = '0;
    w_data = '0;
    r_addr = '0;
    if (gnt0) begin
      ren    = 1'b1;
      r_addr = bus.m0_addr;
    end else if (gnt1) begin
      if (bus.m1_we) begin
        wen    = 1'b1;
        w_addr = bus.m1_addr;
        w_data = bus.m1_wdata;
      end else begin
        ren    = 1'b1;
        r_addr = bus.m1_addr;
      end
    end
  end

  // Read-owner FSM: remembers who gets the memory's registered read data next cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= NONE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = NONE;
    if (gnt0)                     state_d = OWN0;
    else if (gnt1 && !bus.m1_we)  state_d = OWN1;
  end

  always_comb begin
    rvalid0 = 1'b0;
    rvalid1 = 1'b0;
    rdata0  = '0;
    rdata1  = '0;
    case (state_q)
      OWN0: begin
        rvalid0 = 1'b1;
        rdata0  = bus.mem_r_data;
      end
      OWN1: begin
        rvalid1 = 1'b1;
        rdata1  = bus.mem_r_data;
      end
      default: ;
    endcase
  end

  assign bus.m0_gnt     = gnt0;
  assign bus.m1_gnt     = gnt1;
  assign bus.mem_wen    = wen;
  assign bus.mem_w_addr = w_addr;
  assign bus.mem_w_data = w_data;
  assign bus.mem_ren    = ren;
  assign bus.mem_r_addr = r_addr;
  assign bus.m0_rvalid  = rvalid0;
  assign bus.m0_rdata   = rdata0;
  assign bus.m1_rvalid  = rvalid1;
  assign bus.m1_rdata   = rdata1;

endmodule
